// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the memory-side MAR/MDR register stage.
// The depth constant is also used by the word-addressed memory model.
package mem_if_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_TIMEOUT    = 15;
    localparam int MEM_DEPTH      = 1 << DEF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for a pending memory transaction.
// Flags expiry on the cycle whose count reaches TIMEOUT; saturates, never wraps.
module mem_wait_timer
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    // cnt_inc counts the wait cycle in progress, so expiry lands on edge N+TIMEOUT
    always_comb begin
        cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (start) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d   = cnt_inc;
            expired = (cnt_inc >= LIMIT);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_data_interface.sv
// MAR/MDR register stage with a request/ready handshake to word memory.
// MDR feeds the bus mux; the control unit strobes read/write and waits on busy/done.
module mem_data_interface
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] bus_mux_out,
    input  logic                  mar_in,
    input  logic                  mdr_in,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mdr_out,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic mem_rd_q, mem_rd_d;
    logic mem_wr_q, mem_wr_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;

    logic start;
    logic wait_en;
    logic expired;

    assign wait_en = (state_q != IDLE);

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .enable (wait_en),
        .expired(expired)
    );

    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        start    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mar_in) mar_d = bus_mux_out[ADDR_WIDTH-1:0];
                if (mdr_in) mdr_d = bus_mux_out;
                // read has priority; a simultaneous write is dropped
                if (read) begin
                    state_d  = RD_WAIT;
                    mem_rd_d = 1'b1;
                    busy_d   = 1'b1;
                    error_d  = 1'b0;
                    start    = 1'b1;
                end else if (write) begin
                    state_d  = WR_WAIT;
                    mem_wr_d = 1'b1;
                    busy_d   = 1'b1;
                    error_d  = 1'b0;
                    start    = 1'b1;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ready) begin
                    if (state_q == RD_WAIT) mdr_d = mem_data_in;
                    state_d  = IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (expired) begin
                    state_d  = IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    busy_d   = 1'b0;
                    error_d  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= IDLE;
            mar_q    <= '0;
            mdr_q    <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign mdr_out      = mdr_q;
    assign mem_addr     = mar_q;
    assign mem_data_out = mem_wr_q ? mdr_q : '0;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
